amp_seq: RTL
============

AMP_SEQ -- requirements
Module: amp_seq

Interface
REQ-001 Parameter SETTLE_CYC, 250000, clks amp held enabled-but-muted after sht_dwn release (5 ms at 50 MHz).
REQ-002 Parameter COOL_CYC, 2500000, clks in cool-down after fault; also the fault-free RUN time that clears retry_cnt.
REQ-003 Parameter FLT_FILT, 4, consecutive synchronized-low clks of Flt_n that constitute a fault.
REQ-004 Parameter MAX_RETRY, 3, faults tolerated before permanent lockout (1..3).
REQ-005 clk  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 seq_low  input  1  high = low-freq EQ queues full; synchronous to clk.
REQ-008 vld  input  1  one-clk pulse per new audio sample pair; synchronous to clk.
REQ-009 Flt_n  input  1  amp fault, active-low, asynchronous to clk.
REQ-010 sht_dwn  output  1  amp shutdown, high = amp off; registered.
REQ-011 mute  output  1  high = speaker driver forced to mid-scale; registered.
REQ-012 flt_lock  output  1  high = lockout reached; registered.
REQ-013 retry_cnt  output  2  faults since last clear; registered.

Function
REQ-014 Flt_n SHALL pass a 2-flop synchronizer (flops reset to 1), then a saturating filter counter that clears on any synchronized-high sample.
REQ-015 Fault detect SHALL assert when the filter counter reaches FLT_FILT; shorter glitches SHALL have no effect.
REQ-016 States: IDLE, SETTLE, RUN, FAULT, COOL, LOCK; outputs decoded from registered state.
REQ-017 IDLE: sht_dwn=1, mute=1; seq_low=1 sampled -> SETTLE, delay counter cleared.
REQ-018 SETTLE: sht_dwn=0, mute=1; counter increments each clk; at SETTLE_CYC-1 the block SHALL wait for next vld pulse, then -> RUN (unmute aligned to a sample boundary).
REQ-019 RUN: sht_dwn=0, mute=0; counter counts fault-free clks, saturating at COOL_CYC; on reaching COOL_CYC retry_cnt SHALL clear to 0.
REQ-020 Fault detect in SETTLE or RUN -> FAULT; fault detect in IDLE, FAULT, COOL, LOCK ignored.
REQ-021 Flt_n-low-to-sht_dwn-high latency SHALL be exactly FLT_FILT+3 clk edges, counting the first edge that samples Flt_n low.
REQ-022 FAULT: sht_dwn=1, mute=1; lasts exactly 1 clk; retry_cnt increments (saturating at 3); counter cleared; -> COOL.
REQ-023 COOL: sht_dwn=1, mute=1; after COOL_CYC clks -> LOCK if retry_cnt==MAX_RETRY, else -> IDLE.
REQ-024 LOCK: sht_dwn=1, mute=1, flt_lock=1; exit only via rst_n.
REQ-025 seq_low SHALL be ignored outside IDLE; its fall in RUN SHALL NOT change state.
REQ-026 vld SHALL be ignored outside SETTLE's final wait; vld on the same edge the count completes SHALL NOT qualify (next vld used).
REQ-027 Fault detect on the same edge as SETTLE->RUN transition SHALL take priority -> FAULT.
REQ-028 Fault detect on the same edge RUN counter reaches COOL_CYC SHALL go FAULT with retry_cnt incremented, not cleared.
REQ-029 Delay counter SHALL be 22 bits, shared by SETTLE, RUN and COOL, cleared on every state change.

Reset
REQ-030 rst_n low SHALL asynchronously force state=IDLE, sht_dwn=1, mute=1, flt_lock=0, retry_cnt=0, counters=0, sync flops=1.
REQ-031 Reset asserted mid-SETTLE/RUN/COOL/LOCK SHALL take effect immediately; after release, sequence restarts from IDLE requiring seq_low.

Verification (SETTLE_CYC=10, COOL_CYC=20, FLT_FILT=4, MAX_RETRY=3)
REQ-032 Power-up: release rst_n, seq_low=1 at clk 5, vld every 8 clks -> sht_dwn falls clk 6; mute falls on the first vld after 10 SETTLE clks; retry_cnt=0.
REQ-033 Glitch: in RUN, Flt_n low 3 clks -> sht_dwn, mute stay 0; low 4 clks -> sht_dwn=1 exactly 7 edges after first low sample, retry_cnt=1.
REQ-034 Recovery: after fault, Flt_n high -> COOL 20 clks, IDLE, SETTLE, RUN; 20 fault-free RUN clks -> retry_cnt=0.
REQ-035 Lockout: 3 faults each within 20 RUN clks -> after third COOL, flt_lock=1, sht_dwn=1 held 1000 clks despite seq_low=1, vld.
REQ-036 Priority: fault detect coincident with SETTLE->RUN edge -> FAULT, mute never drops; mid-RUN rst_n pulse -> all outputs at reset values same cycle.

Source files
------------

// File: rtl/amp_seq.sv
// -----------------------------------------------------------------------------
// amp_seq -- class-D amplifier power-up / fault sequencer
//
// Purpose:
//   Brings the amplifier out of shutdown, holds it muted while it settles and
//   unmutes on an audio sample boundary. A filtered amplifier fault shuts it
//   down. After a cool-down the amplifier is retried. After MAX_RETRY faults
//   without a long enough fault-free run, the amplifier is locked off until
//   rst_n is asserted.
//
// Ports:
//   clk        in   system clock, all logic on the rising edge
//   rst_n      in   asynchronous active-low reset
//   seq_low    in   high = low-frequency EQ queues full (start request)
//   vld        in   one-clock pulse per new audio sample pair
//   Flt_n      in   amplifier fault, active-low, asynchronous to clk
//   sht_dwn    out  amplifier shutdown, high = amp off (registered)
//   mute       out  high = speaker driver forced to mid-scale (registered)
//   flt_lock   out  high = permanent fault lockout (registered)
//   retry_cnt  out  faults since last clear, saturating at 3 (registered)
// -----------------------------------------------------------------------------
module amp_seq #(
  parameter int SETTLE_CYC = 250000,
  parameter int COOL_CYC   = 2500000,
  parameter int FLT_FILT   = 4,
  parameter int MAX_RETRY  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       seq_low,
  input  logic       vld,
  input  logic       Flt_n,
  output logic       sht_dwn,
  output logic       mute,
  output logic       flt_lock,
  output logic [1:0] retry_cnt
);

  localparam int FW = $clog2(FLT_FILT + 1);

  localparam logic [FW-1:0] FILT_MAX    = FW'(FLT_FILT);
  localparam logic [21:0]   SETTLE_LAST = 22'(SETTLE_CYC - 1);
  localparam logic [21:0]   COOL_LAST   = 22'(COOL_CYC - 1);
  localparam logic [21:0]   COOL_FULL   = 22'(COOL_CYC);
  localparam logic [1:0]    RETRY_MAX   = 2'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_RUN    = 3'd2,
    ST_FAULT  = 3'd3,
    ST_COOL   = 3'd4,
    ST_LOCK   = 3'd5
  } state_e;

  // Output pattern {sht_dwn, mute, flt_lock} for a state. The FSM loads the
  // output flops with the pattern of the state it is entering, so the outputs
  // always match the registered state without any decode after the flops.
  function automatic logic [2:0] out_dec(input state_e st);
    logic [2:0] o;
    case (st)
      ST_SETTLE: o = 3'b010;
      ST_RUN:    o = 3'b000;
      ST_LOCK:   o = 3'b111;
      default:   o = 3'b110;
    endcase
    return o;
  endfunction

  logic          flt_s1_q;
  logic          flt_s2_q;
  logic [FW-1:0] filt_q;
  logic [FW-1:0] filt_d;
  logic          flt_det_s;

  state_e        state_q;
  logic [21:0]   cnt_q;
  logic [1:0]    retry_q;
  logic          sht_dwn_q;
  logic          mute_q;
  logic          flt_lock_q;

  // Filter next value: any high sample restarts the count, otherwise count
  // consecutive low samples and hold at FLT_FILT.
  always_comb begin
    filt_d = filt_q;
    if (flt_s2_q) begin
      filt_d = '0;
    end else if (filt_q != FILT_MAX) begin
      filt_d = filt_q + FW'(1);
    end else begin
      filt_d = filt_q;
    end
  end

  // Fault seen once FLT_FILT consecutive low samples have been counted.
  assign flt_det_s = (filt_q == FILT_MAX);

  // Two-flop synchronizer for the asynchronous fault pin and the glitch filter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flt_s1_q <= 1'b1;
      flt_s2_q <= 1'b1;
      filt_q   <= '0;
    end else begin
      flt_s1_q <= Flt_n;
      flt_s2_q <= flt_s1_q;
      filt_q   <= filt_d;
    end
  end

  // Sequencer FSM with the shared delay counter, retry counter and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 22'd0;
      retry_q    <= 2'd0;
      sht_dwn_q  <= 1'b1;
      mute_q     <= 1'b1;
      flt_lock_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (seq_low) begin
            state_q                          <= ST_SETTLE;
            {sht_dwn_q, mute_q, flt_lock_q}  <= out_dec(ST_SETTLE);
          end else begin
            state_q <= ST_IDLE;
          end
          cnt_q <= 22'd0;
        end

        // Counts to SETTLE_LAST, then waits for a vld sampled while already
        // waiting, so a vld on the completing edge itself is not used.
        ST_SETTLE: begin
          if (flt_det_s) begin
            state_q                         <= ST_FAULT;
            cnt_q                           <= 22'd0;
            {sht_dwn_q, mute_q, flt_lock_q} <= out_dec(ST_FAULT);
          end else if (cnt_q == SETTLE_LAST) begin
            if (vld) begin
              state_q                         <= ST_RUN;
              cnt_q                           <= 22'd0;
              {sht_dwn_q, mute_q, flt_lock_q} <= out_dec(ST_RUN);
            end else begin
              cnt_q <= cnt_q;
            end
          end else begin
            cnt_q <= cnt_q + 22'd1;
          end
        end

        // Fault has priority over the retry clear on the same edge.
        ST_RUN: begin
          if (flt_det_s) begin
            state_q                         <= ST_FAULT;
            cnt_q                           <= 22'd0;
            {sht_dwn_q, mute_q, flt_lock_q} <= out_dec(ST_FAULT);
          end else if (cnt_q != COOL_FULL) begin
            cnt_q <= cnt_q + 22'd1;
            if (cnt_q == COOL_LAST) begin
              retry_q <= 2'd0;
            end else begin
              retry_q <= retry_q;
            end
          end else begin
            cnt_q <= cnt_q;
          end
        end

        ST_FAULT: begin
          state_q                         <= ST_COOL;
          cnt_q                           <= 22'd0;
          retry_q                         <= (retry_q == 2'd3) ? 2'd3 : retry_q + 2'd1;
          {sht_dwn_q, mute_q, flt_lock_q} <= out_dec(ST_COOL);
        end

        ST_COOL: begin
          if (cnt_q == COOL_LAST) begin
            cnt_q <= 22'd0;
            if (retry_q == RETRY_MAX) begin
              state_q                         <= ST_LOCK;
              {sht_dwn_q, mute_q, flt_lock_q} <= out_dec(ST_LOCK);
            end else begin
              state_q                         <= ST_IDLE;
              {sht_dwn_q, mute_q, flt_lock_q} <= out_dec(ST_IDLE);
            end
          end else begin
            cnt_q <= cnt_q + 22'd1;
          end
        end

        ST_LOCK: begin
          state_q <= ST_LOCK;
          cnt_q   <= 22'd0;
        end

        default: begin
          state_q                         <= ST_IDLE;
          cnt_q                           <= 22'd0;
          {sht_dwn_q, mute_q, flt_lock_q} <= out_dec(ST_IDLE);
        end
      endcase
    end
  end

  assign sht_dwn   = sht_dwn_q;
  assign mute      = mute_q;
  assign flt_lock  = flt_lock_q;
  assign retry_cnt = retry_q;

endmodule
